// File: rtl/sa4_cache_pkg.sv
// Shared sizes, FSM encoding and tree-PLRU helpers for the 4-way cache sequencer.
package sa4_cache_pkg;
  localparam int WAYS       = 4;
  localparam int ADDR_W     = 32;
  localparam int INDEX_W    = 6;
  localparam int OFFSET_W   = 5;
  localparam int DATA_W     = 64;
  localparam int CNT_W      = 32;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_WORDS = (1 << OFFSET_W) / (DATA_W / 8);
  localparam int BEAT_W     = $clog2(LINE_WORDS);
  localparam int SETS       = 1 << INDEX_W;
  localparam int LINE_W     = ADDR_W - OFFSET_W;

  typedef enum logic [2:0] {
    ST_IDLE, ST_COMPARE, ST_MEM_REQ, ST_REFILL, ST_TAG_WR, ST_RESP
  } state_t;

  // bit 0 = b0 (root), bit 1 = b1 (ways 0/1), bit 2 = b2 (ways 2/3)
  typedef logic [2:0] plru_t;

  function automatic logic [WAYS-1:0] lowest_one(input logic [WAYS-1:0] v);
    return v & (~v + 4'd1);
  endfunction

  function automatic logic [WAYS-1:0] plru_victim(input plru_t p);
    if (!p[0]) return p[1] ? 4'b0010 : 4'b0001;
    return p[2] ? 4'b1000 : 4'b0100;
  endfunction

  function automatic plru_t plru_update(input plru_t p, input logic [WAYS-1:0] way);
    plru_t n;
    n = p;
    if (way[0])      begin n[0] = 1'b1; n[1] = 1'b1; end
    else if (way[1]) begin n[0] = 1'b1; n[1] = 1'b0; end
    else if (way[2]) begin n[0] = 1'b0; n[2] = 1'b1; end
    else if (way[3]) begin n[0] = 1'b0; n[2] = 1'b0; end
    return n;
  endfunction
endpackage

// File: rtl/sa4_plru_tree.sv
// Combinational tree-PLRU for one set: victim pick and post-access bits.
module sa4_plru_tree
  import sa4_cache_pkg::*;
(
  input  plru_t            bits,
  input  logic [WAYS-1:0]  access_way,
  output logic [WAYS-1:0]  victim,
  output plru_t            next_bits
);
  assign victim    = plru_victim(bits);
  assign next_bits = plru_update(bits, access_way);
endmodule

// File: rtl/sa4_cache_ctrl.sv
// Request sequencer for the 4-way set-associative cache: lookup, PLRU upkeep,
// victim selection and line refill from memory.
module sa4_cache_ctrl
  import sa4_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic [ADDR_W-1:0]   req_addr,
  output logic                req_ready,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic                lookup_en,
  output logic [INDEX_W-1:0]  lookup_index,
  output logic [TAG_W-1:0]    lookup_tag,
  input  logic [WAYS-1:0]     hit_vec,
  input  logic [WAYS-1:0]     valid_vec,
  output logic                mem_req_valid,
  output logic [ADDR_W-1:0]   mem_req_addr,
  input  logic                mem_req_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fill_we,
  output logic [WAYS-1:0]     fill_way,
  output logic [INDEX_W-1:0]  fill_index,
  output logic [BEAT_W-1:0]   fill_word,
  output logic [DATA_W-1:0]   fill_data,
  output logic                tag_we,
  output logic [TAG_W-1:0]    tag_wdata,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);
  state_t              state, state_nx;
  logic [LINE_W-1:0]   line_q;
  logic [WAYS-1:0]     victim_q;
  logic [BEAT_W-1:0]   beat_q;
  plru_t               plru_q [SETS];
  logic [INDEX_W-1:0]  idx_q;
  logic                hit, plru_we;
  logic [WAYS-1:0]     hit_way, inval_way, tree_victim, miss_victim, access_way;
  plru_t               tree_next;
  logic                unused_offset;

  assign unused_offset = ^req_addr[OFFSET_W-1:0];
  assign idx_q         = line_q[INDEX_W-1:0];
  assign hit           = |hit_vec;
  // multi-hit is illegal upstream; lowest way wins if it ever happens
  assign hit_way       = lowest_one(hit_vec);
  assign inval_way     = lowest_one(~valid_vec);
  assign miss_victim   = (valid_vec != '1) ? inval_way : tree_victim;
  assign access_way    = (state == ST_COMPARE) ? hit_way : victim_q;

  sa4_plru_tree u_plru (
    .bits       (plru_q[idx_q]),
    .access_way (access_way),
    .victim     (tree_victim),
    .next_bits  (tree_next)
  );

  always_comb begin
    state_nx      = state;
    req_ready     = 1'b0;
    lookup_en     = 1'b0;
    resp_valid    = 1'b0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    fill_we       = 1'b0;
    tag_we        = 1'b0;
    plru_we       = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          lookup_en = 1'b1;
          state_nx  = ST_COMPARE;
        end
      end
      ST_COMPARE: begin
        if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          plru_we    = 1'b1;
          state_nx   = ST_IDLE;
        end else begin
          state_nx   = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nx = ST_REFILL;
      end
      ST_REFILL: begin
        if (mem_rvalid) begin
          fill_we = 1'b1;
          if (beat_q == BEAT_W'(LINE_WORDS - 1)) state_nx = ST_TAG_WR;
        end
      end
      ST_TAG_WR: begin
        tag_we   = 1'b1;
        plru_we  = 1'b1;
        state_nx = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      line_q   <= '0;
      victim_q <= '0;
      beat_q   <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && req_valid) line_q <= req_addr[ADDR_W-1:OFFSET_W];
      if (state == ST_COMPARE) begin
        if (hit) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
          victim_q <= miss_victim;
          beat_q   <= '0;
        end
      end
      if (fill_we) beat_q <= beat_q + BEAT_W'(1);
      if (plru_we) plru_q[idx_q] <= tree_next;
    end
  end

  assign lookup_index = req_addr[OFFSET_W +: INDEX_W];
  assign lookup_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign mem_req_addr = {line_q, {OFFSET_W{1'b0}}};
  assign fill_way     = victim_q;
  assign fill_index   = idx_q;
  assign fill_word    = beat_q;
  assign fill_data    = mem_rdata;
  assign tag_wdata    = line_q[LINE_W-1 -: TAG_W];
endmodule

// File: tb/tb_sa4_cache_ctrl.sv
// Bench for sa4_cache_ctrl: the bench plays the tag arrays and memory from a
// behavioural cache model and checks every DUT output each cycle.
module tb_sa4_cache_ctrl;
  import sa4_cache_pkg::*;

  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  logic              req_valid = 0, req_ready, resp_valid, resp_hit, lookup_en;
  logic [31:0]       req_addr = 0, mem_req_addr;
  logic [5:0]        lookup_index, fill_index;
  logic [20:0]       lookup_tag, tag_wdata;
  logic [3:0]        hit_vec = 0, valid_vec = 0, fill_way;
  logic              mem_req_valid, mem_req_ready = 0, mem_rvalid = 0, fill_we, tag_we;
  logic [63:0]       mem_rdata = 0, fill_data;
  logic [1:0]        fill_word;
  logic [31:0]       hit_cnt, miss_cnt;

  sa4_cache_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .lookup_en(lookup_en),
    .lookup_index(lookup_index), .lookup_tag(lookup_tag), .hit_vec(hit_vec),
    .valid_vec(valid_vec), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_way(fill_way), .fill_index(fill_index), .fill_word(fill_word),
    .fill_data(fill_data), .tag_we(tag_we), .tag_wdata(tag_wdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int n_chk = 0, n_err = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // cache model: which tag lives in which way, tree-PLRU bits b0/b1/b2, counters
  logic [20:0] m_tag [64][4];
  bit          m_val [64][4];
  bit          m_b0 [64], m_b1 [64], m_b2 [64];
  longint      m_hit = 0, m_miss = 0;
  localparam longint CMAX = 64'hFFFF_FFFF;

  function automatic int plru_pick(input int s);
    int pair;
    pair = m_b0[s] ? 1 : 0;
    return pair * 2 + (pair ? int'(m_b2[s]) : int'(m_b1[s]));
  endfunction

  task automatic plru_touch(input int s, input int w);
    m_b0[s] = (w < 2);
    if (w < 2) m_b1[s] = (w == 0);
    else       m_b2[s] = (w == 2);
  endtask

  // expected outputs for the current cycle, set by the driver
  logic        exp_ready = 1, exp_resp = 0, exp_rhit = 0, exp_lookup = 0;
  logic        exp_mreq = 0, exp_fill = 0, exp_tagwe = 0;
  logic [5:0]  exp_lidx = 0, exp_fidx = 0;
  logic [20:0] exp_ltag = 0, exp_twdata = 0;
  logic [31:0] exp_maddr = 0;
  logic [3:0]  exp_fway = 0;
  logic [1:0]  exp_fword = 0;
  logic [63:0] exp_fdata = 0;

  int          cyc = 0, acc_cyc = 0, last_lat = -1, n_mreq = 0, n_fill = 0;
  logic        last_rhit = 1'bx;
  logic [31:0] last_maddr = 0;
  logic [3:0]  last_fway = 0;
  logic [5:0]  last_fidx = 0;

  always @(negedge clk) begin
    cyc++;
    chk("req_ready", req_ready, exp_ready);
    chk("lookup_en", lookup_en, exp_lookup);
    if (exp_lookup) begin
      chk("lookup_index", lookup_index, exp_lidx);
      chk("lookup_tag", lookup_tag, exp_ltag);
    end
    chk("resp_valid", resp_valid, exp_resp);
    if (exp_resp) chk("resp_hit", resp_hit, exp_rhit);
    chk("mem_req_valid", mem_req_valid, exp_mreq);
    if (exp_mreq) chk("mem_req_addr", mem_req_addr, exp_maddr);
    chk("fill_we", fill_we, exp_fill);
    if (exp_fill) begin
      chk("fill_way", fill_way, exp_fway);
      chk("fill_index", fill_index, exp_fidx);
      chk("fill_word", fill_word, exp_fword);
      chk("fill_data", fill_data, exp_fdata);
    end
    chk("tag_we", tag_we, exp_tagwe);
    if (exp_tagwe) begin
      chk("tag_way", fill_way, exp_fway);
      chk("tag_index", fill_index, exp_fidx);
      chk("tag_wdata", tag_wdata, exp_twdata);
    end
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
    if (lookup_en) acc_cyc = cyc;
    if (resp_valid) begin last_rhit = resp_hit; last_lat = cyc - acc_cyc; end
    if (mem_req_valid) begin last_maddr = mem_req_addr; n_mreq++; end
    if (fill_we) n_fill++;
    if (tag_we) begin last_fway = fill_way; last_fidx = fill_index; end
  end

  always @(posedge clk) if (rst) assert ($onehot0(hit_vec)) else $error("multi-way hit driven");

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reset_mid();
    rst = 0;
    req_valid = 0; exp_ready = 1; exp_resp = 0; exp_lookup = 0;
    exp_mreq = 0; exp_fill = 0; exp_tagwe = 0;
    m_hit = 0; m_miss = 0;
    for (int s = 0; s < 64; s++) begin m_b0[s] = 0; m_b1[s] = 0; m_b2[s] = 0; end
    mem_rvalid = 1;
    step(); step();
    rst = 1;
    step(); step();
    mem_rvalid = 0;
    step();
  endtask

  task automatic do_req(input logic [31:0] a, input int mdly, input bit hold, input int abort_after);
    int s, hw, vw;
    logic [20:0] t;
    logic [3:0] hv, vv;
    s = int'(a[10:5]); t = a[31:11];
    req_valid = 1; req_addr = a;
    exp_ready = 1; exp_lookup = 1; exp_lidx = a[10:5]; exp_ltag = t;
    step();
    if (!hold) req_valid = 0;
    exp_ready = 0; exp_lookup = 0;
    hv = 0; vv = 0; hw = -1;
    for (int w = 0; w < 4; w++) begin
      vv[w] = m_val[s][w];
      if (m_val[s][w] && m_tag[s][w] == t) begin hv[w] = 1; hw = w; end
    end
    hit_vec = hv; valid_vec = vv;
    if (hw >= 0) begin
      exp_resp = 1; exp_rhit = 1;
      step();
      if (m_hit < CMAX) m_hit++;
      plru_touch(s, hw);
      exp_resp = 0; hit_vec = 0; valid_vec = 0; req_valid = 0; exp_ready = 1;
      return;
    end
    vw = -1;
    for (int w = 0; w < 4; w++) if (!m_val[s][w] && vw < 0) vw = w;
    if (vw < 0) vw = plru_pick(s);
    step();
    if (m_miss < CMAX) m_miss++;
    hit_vec = 0; valid_vec = 0;
    exp_mreq = 1; exp_maddr = {a[31:5], 5'b0};
    for (int d = 0; d <= mdly; d++) begin
      mem_req_ready = (d == mdly);
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata = {$urandom, $urandom};
      step();
    end
    mem_req_ready = 0; mem_rvalid = 0; exp_mreq = 0;
    for (int b = 0; b < 4; b++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) step();
      mem_rvalid = 1; mem_rdata = {$urandom, $urandom};
      exp_fill = 1; exp_fway = 4'(1 << vw); exp_fidx = a[10:5];
      exp_fword = 2'(b); exp_fdata = mem_rdata;
      step();
      mem_rvalid = 0; exp_fill = 0;
      if (b == abort_after) begin reset_mid(); return; end
    end
    exp_tagwe = 1; exp_fway = 4'(1 << vw); exp_fidx = a[10:5]; exp_twdata = t;
    step();
    m_tag[s][vw] = t; m_val[s][vw] = 1; plru_touch(s, vw);
    exp_tagwe = 0; exp_resp = 1; exp_rhit = 0;
    step();
    exp_resp = 0; req_valid = 0; exp_ready = 1;
  endtask

  initial begin
    int n0;
    logic [31:0] a;
    for (int s = 0; s < 64; s++) begin
      m_b0[s] = 0; m_b1[s] = 0; m_b2[s] = 0;
      for (int w = 0; w < 4; w++) begin m_val[s][w] = 0; m_tag[s][w] = 0; end
    end
    step(); step();
    rst = 1;
    step();
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_mem_req_addr", mem_req_addr, 0);
    chk("rst_fill_way", fill_way, 0);

    // cold miss
    n0 = n_fill;
    do_req(32'h1fffff50, 1, 0, -1);
    chk("t1_maddr", last_maddr, 32'h1fffff40);
    chk("t1_fidx", last_fidx, 6'h3a);
    chk("t1_fway", last_fway, 4'b0001);
    chk("t1_rhit", last_rhit, 0);
    chk("t1_miss_cnt", miss_cnt, 1);
    chk("t1_beats", n_fill - n0, 4);
    chk("t1_model_miss", m_miss, 1);

    // same line hit
    n0 = n_mreq;
    do_req(32'h1fffff58, 0, 0, -1);
    chk("t2_lat", last_lat, 1);
    chk("t2_rhit", last_rhit, 1);
    chk("t2_hit_cnt", hit_cnt, 1);
    chk("t2_no_mreq", n_mreq - n0, 0);

    // fill set 0x3a, then evict by PLRU
    do_req(32'h1fffff50, 0, 0, -1);
    do_req(32'h1ffff750, 0, 0, -1);
    do_req(32'h1fffef50, 2, 0, -1);
    do_req(32'h1fffe750, 0, 0, -1);
    do_req(32'h1fffdf50, 0, 0, -1);
    chk("t3_victim", last_fway, 4'b0001);
    chk("t3_model_victim", last_fway, 4'(1 << 0));

    do_req(32'h1fffdf50, 0, 0, -1);
    chk("t4_hit_w0", last_rhit, 1);
    do_req(32'h1fffd750, 0, 0, -1);
    chk("t4_victim_w2", last_fway, 4'b0100);
    do_req(32'h1ffff750, 0, 0, -1);
    do_req(32'h1fffe750, 0, 0, -1);
    chk("t4_hit_w3", last_rhit, 1);
    do_req(32'h1fffcf50, 0, 0, -1);
    chk("t4_victim_w0", last_fway, 4'b0001);

    // reset after beat 1 of a refill
    n0 = n_fill;
    do_req(32'h00001000, 0, 0, 1);
    chk("t5_beats", n_fill - n0, 2);
    chk("t5_miss_cnt", miss_cnt, 0);
    chk("t5_hit_cnt", hit_cnt, 0);
    do_req(32'h00001000, 0, 0, -1);
    chk("t5_rereq_miss", last_rhit, 0);
    chk("t5_rereq_cnt", miss_cnt, 1);

    // request held through refill, slow memory accept
    n0 = n_mreq;
    do_req(32'h00002020, 3, 1, -1);
    chk("t6_rhit", last_rhit, 0);
    chk("t6_mreq_cycles", n_mreq - n0, 4);

    for (int i = 0; i < 200; i++) begin
      int sets [4] = '{0, 1, 2, 58};
      a = {21'($urandom_range(0, 5)), 6'(sets[$urandom_range(0, 3)]), 5'($urandom)};
      do_req(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end
    chk("end_hit_cnt", hit_cnt, m_hit);
    chk("end_miss_cnt", miss_cnt, m_miss);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
